trig_readout_sched: RTL and testbench

Readout scheduler that sits between the trigger block and the shared SCROD readout link. When the trigger logic raises its veto request, the block latches the set of enabled SCRODs and grants the single readout path to each one in turn as its event data becomes ready. It applies a per-SCROD timeout and, once every SCROD has been serviced or timed out, pulses `TRG_VETO_RESET` to re-arm triggering. It also keeps event and timeout statistics for the register interface.

---
 rtl/trig_readout_sched_if.sv | 47 ++++
 rtl/trig_readout_sched.sv | 143 ++++++++++++++
 tb/tb_trig_readout_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_readout_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : trig_readout_sched_if
// Description : Bundles the trigger-side and readout-link signals of the
//               readout scheduler.
//               master : trigger block / readout link side. Drives veto
//                        request, mask, data-ready and done; observes grant,
//                        release pulse and statistics.
//               slave  : the scheduler itself.
//               Signals:
//                 TRG_NEEDS_VETO  veto request level from the trigger block
//                 TRG_MASK        enabled SCRODs, latched at event start
//                 DATA_RDY        per-SCROD event data available
//                 RD_DONE         end-of-transfer pulse from the readout link
//                 RD_GRANT        one-hot (or zero) readout grant
//                 TRG_VETO_RESET  one-cycle trigger re-arm pulse
//                 BUSY            scheduler not idle
//                 TIMEOUT_FLAGS   SCRODs that timed out in the last event
//                 EVENT_COUNT     completed events (wraps)
//                 TIMEOUT_COUNT   events with a timeout (saturates)
// Revision    : 1.0 - initial release
// ============================================================================
interface trig_readout_sched_if #(
  parameter int N_SCROD = 12
);
  logic               TRG_NEEDS_VETO;
  logic [N_SCROD-1:0] TRG_MASK;
  logic [N_SCROD-1:0] DATA_RDY;
  logic               RD_DONE;
  logic [N_SCROD-1:0] RD_GRANT;
  logic               TRG_VETO_RESET;
  logic               BUSY;
  logic [N_SCROD-1:0] TIMEOUT_FLAGS;
  logic [31:0]        EVENT_COUNT;
  logic [15:0]        TIMEOUT_COUNT;

  modport master (
    output TRG_NEEDS_VETO, TRG_MASK, DATA_RDY, RD_DONE,
    input  RD_GRANT, TRG_VETO_RESET, BUSY, TIMEOUT_FLAGS, EVENT_COUNT, TIMEOUT_COUNT
  );

  modport slave (
    input  TRG_NEEDS_VETO, TRG_MASK, DATA_RDY, RD_DONE,
    output RD_GRANT, TRG_VETO_RESET, BUSY, TIMEOUT_FLAGS, EVENT_COUNT, TIMEOUT_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/trig_readout_sched.sv
`default_nettype none
// ============================================================================
// Module      : trig_readout_sched
// Description : Readout scheduler between the trigger block and the shared
//               SCROD readout link. On a veto request it latches the enabled
//               SCRODs, grants the link to each ready one in turn (lowest
//               index first), applies a no-progress timeout, then pulses
//               TRG_VETO_RESET once to re-arm triggering.
//               Ports:
//                 CLK_42MHZ  single clock, rising edge
//                 RESET      asynchronous active-high reset
//                 bus        trig_readout_sched_if.slave (handshake, grant,
//                            release pulse and statistics)
// Revision    : 1.0 - initial release
// ============================================================================
module trig_readout_sched #(
  parameter int N_SCROD        = 12,
  parameter int TIMEOUT_CYCLES = 42000
) (
  input wire                  CLK_42MHZ,
  input wire                  RESET,
  trig_readout_sched_if.slave bus
);

  localparam logic [15:0] c_timer_last = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_GRANT   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  state_t             r_state;
  logic [N_SCROD-1:0] r_pending;
  logic [N_SCROD-1:0] r_grant;
  logic               r_veto_reset;
  logic [N_SCROD-1:0] r_flags;
  logic [31:0]        r_event_count;
  logic [15:0]        r_timeout_count;
  logic [15:0]        r_timer;

  logic [N_SCROD-1:0] w_cand;
  logic [N_SCROD-1:0] w_pick;
  logic [N_SCROD-1:0] w_left;
  logic               w_timeout;

  // Only SCRODs still owed a readout compete; stray DATA_RDY is masked off.
  assign w_cand    = r_pending & bus.DATA_RDY;
  // Two's-complement trick isolates the lowest set bit: lowest index wins.
  assign w_pick    = w_cand & (-w_cand);
  // Pending set once the currently granted SCROD is retired.
  assign w_left    = r_pending & ~r_grant;
  assign w_timeout = (r_timer == c_timer_last);

  always_ff @(posedge CLK_42MHZ or posedge RESET) begin
    if (RESET) begin
      r_state         <= ST_IDLE;
      r_pending       <= '0;
      r_grant         <= '0;
      r_veto_reset    <= 1'b0;
      r_flags         <= '0;
      r_event_count   <= '0;
      r_timeout_count <= '0;
      r_timer         <= '0;
    end else begin
      r_veto_reset <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.TRG_NEEDS_VETO) begin
            r_pending <= bus.TRG_MASK;
            r_flags   <= '0;
            r_timer   <= '0;
            r_state   <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (r_pending == '0) begin
            r_state <= ST_RELEASE;
          end else if (w_cand != '0) begin
            // A grant is progress, so it takes precedence over an expiring
            // timer in the same cycle.
            r_grant <= w_pick;
            r_timer <= '0;
            r_state <= ST_GRANT;
          end else if (w_timeout) begin
            r_flags   <= r_pending;
            r_pending <= '0;
            r_grant   <= '0;
            if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
            r_state   <= ST_RELEASE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        ST_GRANT: begin
          if (bus.RD_DONE) begin
            // RD_DONE beats a coincident timeout. When the last SCROD retires
            // go straight to RELEASE so the re-arm pulse is not delayed.
            r_pending <= w_left;
            r_grant   <= '0;
            r_timer   <= '0;
            r_state   <= (w_left == '0) ? ST_RELEASE : ST_SELECT;
          end else if (w_timeout) begin
            r_flags   <= r_pending;
            r_pending <= '0;
            r_grant   <= '0;
            if (r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
            r_state   <= ST_RELEASE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        ST_RELEASE: begin
          r_veto_reset  <= 1'b1;
          r_event_count <= r_event_count + 32'd1;
          r_state       <= ST_HOLDOFF;
        end

        ST_HOLDOFF: begin
          // A veto level still high from the finished event must not start
          // a duplicate one; wait for it to drop first.
          if (!bus.TRG_NEEDS_VETO) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.RD_GRANT       = r_grant;
  assign bus.TRG_VETO_RESET = r_veto_reset;
  assign bus.BUSY           = (r_state != ST_IDLE);
  assign bus.TIMEOUT_FLAGS  = r_flags;
  assign bus.EVENT_COUNT    = r_event_count;
  assign bus.TIMEOUT_COUNT  = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_trig_readout_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_readout_sched
// Description : Self-checking bench for trig_readout_sched. Expected grants
//               are queued when an event is launched and popped as the DUT
//               raises them; end-of-event state is checked against a small
//               counter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_readout_sched;
  localparam int N  = 12;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trig_readout_sched_if #(.N_SCROD(N)) bus ();

  trig_readout_sched #(.N_SCROD(N), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_42MHZ (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  logic         rsp_done = 1'b0;
  logic         man_done = 1'b0;
  logic [N-1:0] done_en  = '0;
  assign bus.RD_DONE = rsp_done | man_done;

  int           n_vec     = 0;
  int           n_miss    = 0;
  int           n_release = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_grant = '0;
  logic [31:0]  exp_ev = '0;
  logic [15:0]  exp_to = '0;

  typedef struct {
    logic [N-1:0]      mask;
    logic [N-1:0]      rdy;
    logic [N-1:0]      den;
    int                n_gr;
    logic [2:0][N-1:0] gr;
    logic [N-1:0]      flags;
    int                to_inc;
  } vec_t;

  vec_t vt[7];

  function automatic vec_t mk(input logic [N-1:0] mask, input logic [N-1:0] rdy,
                              input logic [N-1:0] den, input int n,
                              input logic [N-1:0] g0, input logic [N-1:0] g1,
                              input logic [N-1:0] g2, input logic [N-1:0] flags,
                              input int to_inc);
    vec_t v;
    v.mask = mask; v.rdy = rdy; v.den = den; v.n_gr = n;
    v.gr[0] = g0; v.gr[1] = g1; v.gr[2] = g2;
    v.flags = flags; v.to_inc = to_inc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  // Grant monitor: every new nonzero grant must be the next queued one.
  always @(negedge clk) begin
    if (bus.TRG_VETO_RESET === 1'b1) n_release++;
    if (bus.RD_GRANT !== prev_grant && bus.RD_GRANT !== '0) begin
      if (exp_q.size() == 0) check("grant_unexpected", 32'(bus.RD_GRANT), 32'h0);
      else                   check("grant_order", 32'(bus.RD_GRANT), 32'(exp_q.pop_front()));
    end
    prev_grant = bus.RD_GRANT;
  end

  // Readout link model: RD_DONE sampled three edges after the grant appears.
  initial begin : responder
    forever begin
      @(negedge clk);
      if ((bus.RD_GRANT & done_en) != '0) begin
        repeat (2) @(negedge clk);
        rsp_done = 1'b1;
        @(negedge clk);
        rsp_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_release(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (bus.TRG_VETO_RESET === 1'b1) seen = 1'b1;
    end
    check({name, "_release_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic finish_event(input string name, input int start_rel,
                              input logic [N-1:0] flags);
    bit idle = 1'b0;
    bus.TRG_NEEDS_VETO = 1'b0;
    for (int c = 0; c < 10 && !idle; c++) begin
      @(negedge clk);
      if (bus.BUSY === 1'b0) idle = 1'b1;
    end
    #1;
    check({name, "_idle"},       32'(idle), 32'd1);
    check({name, "_pulses"},     32'(n_release - start_rel), 32'd1);
    check({name, "_grants_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_flags"},      32'(bus.TIMEOUT_FLAGS), 32'(flags));
    check({name, "_event_cnt"},  bus.EVENT_COUNT, exp_ev);
    check({name, "_to_cnt"},     32'(bus.TIMEOUT_COUNT), 32'(exp_to));
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int start_rel;
    @(negedge clk);
    done_en = v.den;
    for (int g = 0; g < v.n_gr; g++) exp_q.push_back(v.gr[g]);
    start_rel = n_release;
    bus.TRG_MASK       = v.mask;
    bus.DATA_RDY       = v.rdy;
    bus.TRG_NEEDS_VETO = 1'b1;
    @(negedge clk);
    bus.TRG_MASK = ~v.mask;            // must be ignored until the next event
    exp_ev++;
    if (v.to_inc != 0) exp_to++;
    wait_release(name);
    finish_event(name, start_rel, v.flags);
  endtask

  task automatic wait_grant(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.RD_GRANT !== '0) seen = 1'b1;
    end
    check({name, "_grant_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin : main
    int start_rel;
    bus.TRG_NEEDS_VETO = 1'b0;
    bus.TRG_MASK       = '0;
    bus.DATA_RDY       = '0;

    vt[0] = mk(12'h005, 12'hFFF, 12'hFFF, 2, 12'h001, 12'h004, 12'h000, 12'h000, 0);
    vt[1] = mk(12'h003, 12'h002, 12'hFFF, 1, 12'h002, 12'h000, 12'h000, 12'h001, 1);
    vt[2] = mk(12'h000, 12'hFFF, 12'hFFF, 0, 12'h000, 12'h000, 12'h000, 12'h000, 0);
    vt[3] = mk(12'h0A0, 12'h0F0, 12'hFFF, 2, 12'h020, 12'h080, 12'h000, 12'h000, 0);
    vt[4] = mk(12'h800, 12'h7FF, 12'hFFF, 0, 12'h000, 12'h000, 12'h000, 12'h800, 1);
    vt[5] = mk(12'h00C, 12'h00C, 12'h008, 1, 12'h004, 12'h000, 12'h000, 12'h00C, 1);
    vt[6] = mk(12'h811, 12'hFFF, 12'hFFF, 3, 12'h001, 12'h010, 12'h800, 12'h000, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant",   32'(bus.RD_GRANT), 32'h0);
    check("rst_pulse",   32'(bus.TRG_VETO_RESET), 32'h0);
    check("rst_busy",    32'(bus.BUSY), 32'h0);
    check("rst_flags",   32'(bus.TIMEOUT_FLAGS), 32'h0);
    check("rst_evcnt",   bus.EVENT_COUNT, 32'h0);
    check("rst_tocnt",   32'(bus.TIMEOUT_COUNT), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Empty mask: pulse exactly two edges after veto, held veto keeps HOLDOFF
    @(negedge clk);
    start_rel = n_release;
    done_en = 12'hFFF;
    bus.TRG_MASK = '0;
    bus.TRG_NEEDS_VETO = 1'b1;
    exp_ev++;
    @(negedge clk);
    check("m0_busy_t",   32'(bus.BUSY), 32'd1);
    check("m0_pulse_t",  32'(bus.TRG_VETO_RESET), 32'd0);
    @(negedge clk);
    check("m0_pulse_t1", 32'(bus.TRG_VETO_RESET), 32'd0);
    @(negedge clk);
    check("m0_pulse_t2", 32'(bus.TRG_VETO_RESET), 32'd1);
    @(negedge clk);
    check("m0_pulse_t3", 32'(bus.TRG_VETO_RESET), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("hold_busy",   32'(bus.BUSY), 32'd1);
    check("hold_pulses", 32'(n_release - start_rel), 32'd1);
    finish_event("hold", start_rel, 12'h000);
    run_vec(vt[0], "rearm");

    // Veto drops right after acceptance: event still completes
    @(negedge clk);
    start_rel = n_release;
    done_en = 12'hFFF;
    exp_q.push_back(12'h001);
    exp_q.push_back(12'h004);
    bus.TRG_MASK = 12'h005;
    bus.DATA_RDY = 12'hFFF;
    bus.TRG_NEEDS_VETO = 1'b1;
    exp_ev++;
    @(negedge clk);
    bus.TRG_NEEDS_VETO = 1'b0;
    wait_release("vdrop");
    finish_event("vdrop", start_rel, 12'h000);

    // RD_DONE on the exact timeout cycle: done wins, no flag, no count
    @(negedge clk);
    start_rel = n_release;
    done_en = '0;
    exp_q.push_back(12'h001);
    bus.TRG_MASK = 12'h001;
    bus.DATA_RDY = 12'h001;
    bus.TRG_NEEDS_VETO = 1'b1;
    exp_ev++;
    wait_grant("coin");
    repeat (TO - 1) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    wait_release("coin");
    finish_event("coin", start_rel, 12'h000);

    // Asynchronous reset while a grant is outstanding
    @(negedge clk);
    done_en = '0;
    exp_q.push_back(12'h002);
    bus.TRG_MASK = 12'h002;
    bus.DATA_RDY = 12'h002;
    bus.TRG_NEEDS_VETO = 1'b1;
    wait_grant("arst");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_grant", 32'(bus.RD_GRANT), 32'h0);
    check("arst_busy",  32'(bus.BUSY), 32'h0);
    check("arst_evcnt", bus.EVENT_COUNT, 32'h0);
    check("arst_tocnt", 32'(bus.TIMEOUT_COUNT), 32'h0);
    bus.TRG_NEEDS_VETO = 1'b0;
    exp_q.delete();
    exp_ev = '0;
    exp_to = '0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(vt[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
